// File: rtl/rr_arbiter_8_pkg.sv
// Shared definitions for the 8-way round-robin arbiter.
//   NUM_REQ : number of requesters
//   ID_W    : width of a requester index
//   state_e : arbiter FSM state
package rr_arbiter_8_pkg;

    localparam int unsigned NUM_REQ = 8;
    localparam int unsigned ID_W    = 3;

    typedef enum logic {
        IDLE,
        GRANT
    } state_e;

endpackage

// File: rtl/rr_pick_next.sv
// Combinational rotate-priority search.
// Scans req starting at (last_id+1) mod 8, upward with wrap 7->0, and returns the
// first set bit.
//   req     : candidate request vector
//   last_id : index of the previous winner; it has the lowest priority this round
//   found   : at least one candidate bit is set
//   next_id : index of the winner; 0 when found=0
module rr_pick_next
    import rr_arbiter_8_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_id,
    output logic               found,
    output logic [ID_W-1:0]    next_id
);

    logic [ID_W-1:0] idx;

    always_comb begin
        found   = 1'b0;
        next_id = '0;
        idx     = '0;
        // i = NUM_REQ wraps back to last_id itself, so it is checked last.
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = last_id + ID_W'(i);
            if (!found && req[idx]) begin
                found   = 1'b1;
                next_id = idx;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter sharing one resource among 8 requesters.
// The grant holds until the owner releases it, or until it has been held MAX_HOLD
// cycles while others wait (unless lock is high). All outputs are registered.
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   en        : arbitration enable; no new grant is issued while low
//   req       : level-held request vector
//   lock      : suppresses preemption of the current owner
//   gnt       : one-hot grant, 0 when idle
//   gnt_id    : binary index of the owner; holds its last value when idle
//   gnt_valid : a grant is active
//   preempt   : one-cycle pulse on the cycle a forced rotation takes effect
module rr_arbiter_8
    import rr_arbiter_8_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    input  logic               lock,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id,
    output logic               gnt_valid,
    output logic               preempt
);

    localparam int unsigned HOLD_W   = (MAX_HOLD <= 1) ? 1 : $clog2(MAX_HOLD);
    // Saturation point of the hold counter; with preemption disabled it just parks at 0.
    localparam int unsigned HOLD_MAX = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;

    state_e              state_q, state_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [ID_W-1:0]     last_id_q, last_id_d;
    logic [ID_W-1:0]     gnt_id_q, gnt_id_d;
    logic                gnt_valid_q, gnt_valid_d;
    logic                preempt_q, preempt_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;

    logic [NUM_REQ-1:0]  cand;
    logic                found;
    logic [ID_W-1:0]     next_id;
    logic                hold_at_max;
    logic                do_preempt;

    // The owner never competes against itself: gnt_q is 0 in IDLE and one-hot(owner)
    // in GRANT, so masking with it covers both release and preemption.
    assign cand = req & ~gnt_q;

    rr_pick_next u_pick (
        .req     (cand),
        .last_id (last_id_q),
        .found   (found),
        .next_id (next_id)
    );

    assign hold_at_max = (hold_cnt_q == HOLD_W'(HOLD_MAX));
    assign do_preempt  = (MAX_HOLD != 0) && hold_at_max && !lock && en && found;

    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        last_id_d   = last_id_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        preempt_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (en && found) begin
                    state_d     = GRANT;
                    gnt_id_d    = next_id;
                    last_id_d   = next_id;
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = '0;
                end
            end
            GRANT: begin
                if (!req[gnt_id_q]) begin
                    if (en && found) begin
                        gnt_id_d   = next_id;
                        last_id_d  = next_id;
                        hold_cnt_d = '0;
                    end else begin
                        state_d     = IDLE;
                        gnt_valid_d = 1'b0;
                        hold_cnt_d  = '0;
                    end
                end else if (do_preempt) begin
                    gnt_id_d   = next_id;
                    last_id_d  = next_id;
                    hold_cnt_d = '0;
                    preempt_d  = 1'b1;
                end else if (!hold_at_max) begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d     = IDLE;
                gnt_valid_d = 1'b0;
            end
        endcase

        gnt_d = '0;
        if (gnt_valid_d) begin
            gnt_d[gnt_id_d] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hold_cnt_q  <= '0;
            last_id_q   <= ID_W'(NUM_REQ - 1);
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            preempt_q   <= 1'b0;
            gnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            last_id_q   <= last_id_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            preempt_q   <= preempt_d;
            gnt_q       <= gnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;
    assign preempt   = preempt_q;

endmodule
